// File: rtl/alarm_key_entry.sv
// Keypad entry for the alarm clock: collects four BCD digits, range-checks them
// as HH:MM on an ALARM/TIME command and strobes the matching load.
module alarm_key_entry #(
   parameter int unsigned TIMEOUT_SECS = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       key_valid,
   input  logic       one_second,
   output logic [3:0] new_alarm_ms_hr,
   output logic [3:0] new_alarm_ls_hr,
   output logic [3:0] new_alarm_ms_min,
   output logic [3:0] new_alarm_ls_min,
   output logic       load_new_alarm,
   output logic       load_new_time,
   output logic       show_new_time,
   output logic       entry_error
);

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BUF_W   = 4 * DIGIT_W;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned TIMER_W = 8;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ENTRY = 1'b1;

   localparam logic [DIGIT_W-1:0] KEY_ALARM  = 4'd10;
   localparam logic [DIGIT_W-1:0] KEY_TIME   = 4'd11;
   localparam logic [CNT_W-1:0]   CNT_FULL   = 3'd4;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_SECS - 1);

   logic [0:0]         state, state_next;
   logic [BUF_W-1:0]   buf_q, buf_next;
   logic [CNT_W-1:0]   digit_count, count_next;
   logic [TIMER_W-1:0] timer, timer_next;
   logic               load_alarm_next, load_time_next, error_next, show_next;
   logic               key_is_digit, key_is_cmd, buf_valid;

   assign key_is_digit = (key <= 4'd9);
   assign key_is_cmd   = (key == KEY_ALARM) || (key == KEY_TIME);

   // HH:MM range check on the current buffer: 00:00 .. 23:59
   assign buf_valid = (buf_q[15:12] <= 4'd2) &&
                      (buf_q[11:8] <= ((buf_q[15:12] == 4'd2) ? 4'd3 : 4'd9)) &&
                      (buf_q[7:4] <= 4'd5) &&
                      (buf_q[3:0] <= 4'd9);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         buf_q          <= '0;
         digit_count    <= '0;
         timer          <= '0;
         load_new_alarm <= 1'b0;
         load_new_time  <= 1'b0;
         entry_error    <= 1'b0;
         show_new_time  <= 1'b0;
      end else begin
         state          <= state_next;
         buf_q          <= buf_next;
         digit_count    <= count_next;
         timer          <= timer_next;
         load_new_alarm <= load_alarm_next;
         load_new_time  <= load_time_next;
         entry_error    <= error_next;
         show_new_time  <= show_next;
      end
   end

   // Next-state and next-output logic; a valid key always wins over a tick.
   always_comb begin
      state_next      = state;
      buf_next        = buf_q;
      count_next      = digit_count;
      timer_next      = timer;
      load_alarm_next = 1'b0;
      load_time_next  = 1'b0;
      error_next      = 1'b0;
      case (state)
         IDLE: begin
            if (key_valid && key_is_digit) begin
               buf_next   = {12'd0, key};
               count_next = 3'd1;
               timer_next = '0;
               state_next = ENTRY;
            end
         end
         ENTRY: begin
            if (key_valid && key_is_digit) begin
               buf_next   = {buf_q[11:0], key};
               count_next = (digit_count == CNT_FULL) ? CNT_FULL : digit_count + 3'd1;
               timer_next = '0;
            end else if (key_valid && key_is_cmd) begin
               if ((digit_count == CNT_FULL) && buf_valid) begin
                  load_alarm_next = (key == KEY_ALARM);
                  load_time_next  = (key == KEY_TIME);
               end else begin
                  error_next = 1'b1;
                  buf_next   = '0;
               end
               count_next = '0;
               timer_next = '0;
               state_next = IDLE;
            end else if (one_second && !key_valid) begin
               if (timer == TIMER_LAST) begin
                  buf_next   = '0;
                  count_next = '0;
                  timer_next = '0;
                  state_next = IDLE;
               end else begin
                  timer_next = timer + 8'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      show_next = (state_next == ENTRY);
   end

   assign new_alarm_ms_hr  = buf_q[15:12];
   assign new_alarm_ls_hr  = buf_q[11:8];
   assign new_alarm_ms_min = buf_q[7:4];
   assign new_alarm_ls_min = buf_q[3:0];

endmodule

// File: tb/tb_alarm_key_entry.sv
// Scoreboard bench for alarm_key_entry: each cycle pushes its expected output
// snapshot, and each scenario task pops and compares what the DUT produced.
module tb_alarm_key_entry;

   typedef struct packed {
      logic [15:0] digits;
      logic        la;
      logic        lt;
      logic        show;
      logic        err;
   } snap_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] key = 4'd0;
   logic       key_valid = 1'b0;
   logic       one_second = 1'b0;
   logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
   logic       load_new_alarm, load_new_time, show_new_time, entry_error;

   int n_cmp = 0;
   int n_err = 0;
   snap_t exp_q[$];
   snap_t obs_q[$];

   alarm_key_entry #(.TIMEOUT_SECS(10)) dut (
      .clock(clock), .reset(reset), .key(key), .key_valid(key_valid),
      .one_second(one_second),
      .new_alarm_ms_hr(ms_hr), .new_alarm_ls_hr(ls_hr),
      .new_alarm_ms_min(ms_min), .new_alarm_ls_min(ls_min),
      .load_new_alarm(load_new_alarm), .load_new_time(load_new_time),
      .show_new_time(show_new_time), .entry_error(entry_error)
   );

   always #5 clock = ~clock;

   function automatic snap_t mk(input logic [15:0] b, input logic la, input logic lt,
                                input logic sh, input logic er);
      snap_t s;
      s.digits = b; s.la = la; s.lt = lt; s.show = sh; s.err = er;
      return s;
   endfunction

   function automatic snap_t observe();
      return mk({ms_hr, ls_hr, ms_min, ls_min}, load_new_alarm, load_new_time,
                show_new_time, entry_error);
   endfunction

   // One clock of stimulus; expected result queued with it, DUT result queued after the edge.
   task automatic cycle(input logic [3:0] k, input logic kv, input logic tk, input snap_t e);
      @(negedge clock);
      key = k; key_valid = kv; one_second = tk;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      obs_q.push_back(observe());
      key_valid = 1'b0; one_second = 1'b0;
   endtask

   task automatic test_reset();
      snap_t e, o;
      int step;
      reset = 1'b1;
      #1;
      e = mk(16'h0000, 0, 0, 0, 0);
      o = observe();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset_async: got %h want %h", o, e); end
      cycle(4'd5, 1'b1, 1'b0, mk(16'h0000, 0, 0, 0, 0));
      @(negedge clock); reset = 1'b0;
      cycle(4'd0, 1'b0, 1'b0, mk(16'h0000, 0, 0, 0, 0));
      step = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL reset step %0d: got %h want %h", step, o, e); end
         step++;
      end
   endtask

   task automatic test_alarm_load();
      snap_t e, o;
      int step;
      cycle(4'd0, 1, 0, mk(16'h0000, 0, 0, 1, 0));
      cycle(4'd7, 1, 0, mk(16'h0007, 0, 0, 1, 0));
      cycle(4'd3, 1, 0, mk(16'h0073, 0, 0, 1, 0));
      cycle(4'd0, 1, 0, mk(16'h0730, 0, 0, 1, 0));
      cycle(4'd10, 1, 0, mk(16'h0730, 1, 0, 0, 0));
      cycle(4'd0, 0, 0, mk(16'h0730, 0, 0, 0, 0));
      // 23:59 is the upper boundary and must be accepted
      cycle(4'd2, 1, 0, mk(16'h0002, 0, 0, 1, 0));
      cycle(4'd3, 1, 0, mk(16'h0023, 0, 0, 1, 0));
      cycle(4'd5, 1, 0, mk(16'h0235, 0, 0, 1, 0));
      cycle(4'd9, 1, 0, mk(16'h2359, 0, 0, 1, 0));
      cycle(4'd10, 1, 0, mk(16'h2359, 1, 0, 0, 0));
      cycle(4'd0, 0, 0, mk(16'h2359, 0, 0, 0, 0));
      step = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL alarm_load step %0d: got %h want %h", step, o, e); end
         step++;
      end
   endtask

   task automatic test_time_load();
      snap_t e, o;
      int step;
      cycle(4'd1, 1, 0, mk(16'h0001, 0, 0, 1, 0));
      cycle(4'd2, 1, 0, mk(16'h0012, 0, 0, 1, 0));
      cycle(4'd3, 1, 0, mk(16'h0123, 0, 0, 1, 0));
      cycle(4'd4, 1, 0, mk(16'h1234, 0, 0, 1, 0));
      cycle(4'd5, 1, 0, mk(16'h2345, 0, 0, 1, 0));
      cycle(4'd11, 1, 0, mk(16'h2345, 0, 1, 0, 0));
      cycle(4'd11, 1, 0, mk(16'h2345, 0, 0, 0, 0));
      step = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL time_load step %0d: got %h want %h", step, o, e); end
         step++;
      end
   endtask

   task automatic test_errors();
      snap_t e, o;
      int step;
      cycle(4'd2, 1, 0, mk(16'h0002, 0, 0, 1, 0));
      cycle(4'd4, 1, 0, mk(16'h0024, 0, 0, 1, 0));
      cycle(4'd0, 1, 0, mk(16'h0240, 0, 0, 1, 0));
      cycle(4'd0, 1, 0, mk(16'h2400, 0, 0, 1, 0));
      cycle(4'd10, 1, 0, mk(16'h0000, 0, 0, 0, 1));
      cycle(4'd0, 0, 0, mk(16'h0000, 0, 0, 0, 0));
      cycle(4'd1, 1, 0, mk(16'h0001, 0, 0, 1, 0));
      cycle(4'd9, 1, 0, mk(16'h0019, 0, 0, 1, 0));
      cycle(4'd6, 1, 0, mk(16'h0196, 0, 0, 1, 0));
      cycle(4'd0, 1, 0, mk(16'h1960, 0, 0, 1, 0));
      cycle(4'd11, 1, 0, mk(16'h0000, 0, 0, 0, 1));
      cycle(4'd0, 0, 0, mk(16'h0000, 0, 0, 0, 0));
      cycle(4'd1, 1, 0, mk(16'h0001, 0, 0, 1, 0));
      cycle(4'd2, 1, 0, mk(16'h0012, 0, 0, 1, 0));
      cycle(4'd3, 1, 0, mk(16'h0123, 0, 0, 1, 0));
      cycle(4'd10, 1, 0, mk(16'h0000, 0, 0, 0, 1));
      cycle(4'd0, 0, 0, mk(16'h0000, 0, 0, 0, 0));
      step = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL errors step %0d: got %h want %h", step, o, e); end
         step++;
      end
   endtask

   task automatic test_timeout();
      snap_t e, o;
      int step;
      cycle(4'd5, 1, 0, mk(16'h0005, 0, 0, 1, 0));
      for (int i = 0; i < 9; i++) cycle(4'd0, 0, 1, mk(16'h0005, 0, 0, 1, 0));
      cycle(4'd0, 0, 1, mk(16'h0000, 0, 0, 0, 0));
      cycle(4'd0, 0, 0, mk(16'h0000, 0, 0, 0, 0));
      // digit coincident with the 10th tick keeps the entry alive and restarts the timer
      cycle(4'd5, 1, 0, mk(16'h0005, 0, 0, 1, 0));
      for (int i = 0; i < 9; i++) cycle(4'd0, 0, 1, mk(16'h0005, 0, 0, 1, 0));
      cycle(4'd6, 1, 1, mk(16'h0056, 0, 0, 1, 0));
      for (int i = 0; i < 9; i++) cycle(4'd0, 0, 1, mk(16'h0056, 0, 0, 1, 0));
      cycle(4'd0, 0, 1, mk(16'h0000, 0, 0, 0, 0));
      step = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL timeout step %0d: got %h want %h", step, o, e); end
         step++;
      end
   endtask

   task automatic test_ignored();
      snap_t e, o;
      int step;
      cycle(4'd1, 1, 0, mk(16'h0001, 0, 0, 1, 0));
      cycle(4'd2, 1, 0, mk(16'h0012, 0, 0, 1, 0));
      cycle(4'd0, 1, 0, mk(16'h0120, 0, 0, 1, 0));
      cycle(4'd0, 1, 0, mk(16'h1200, 0, 0, 1, 0));
      cycle(4'd10, 1, 0, mk(16'h1200, 1, 0, 0, 0));
      for (int k = 10; k < 16; k++) cycle(4'(k), 1, 0, mk(16'h1200, 0, 0, 0, 0));
      cycle(4'd4, 1, 0, mk(16'h0004, 0, 0, 1, 0));
      for (int i = 0; i < 5; i++) cycle(4'd0, 0, 1, mk(16'h0004, 0, 0, 1, 0));
      cycle(4'd13, 1, 0, mk(16'h0004, 0, 0, 1, 0));
      for (int i = 0; i < 4; i++) cycle(4'd0, 0, 1, mk(16'h0004, 0, 0, 1, 0));
      cycle(4'd0, 0, 1, mk(16'h0000, 0, 0, 0, 0));
      step = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL ignored step %0d: got %h want %h", step, o, e); end
         step++;
      end
   endtask

   task automatic test_reset_mid_entry();
      snap_t e, o;
      int step;
      cycle(4'd1, 1, 0, mk(16'h0001, 0, 0, 1, 0));
      cycle(4'd2, 1, 0, mk(16'h0012, 0, 0, 1, 0));
      cycle(4'd3, 1, 0, mk(16'h0123, 0, 0, 1, 0));
      @(negedge clock);
      reset = 1'b1;
      #1;
      e = mk(16'h0000, 0, 0, 0, 0);
      o = observe();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset_mid_entry: got %h want %h", o, e); end
      @(negedge clock); reset = 1'b0;
      cycle(4'd10, 1, 0, mk(16'h0000, 0, 0, 0, 0));
      cycle(4'd0, 0, 0, mk(16'h0000, 0, 0, 0, 0));
      step = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL reset_mid_entry step %0d: got %h want %h", step, o, e); end
         step++;
      end
   endtask

   initial begin
      test_reset();
      test_alarm_load();
      test_time_load();
      test_errors();
      test_timeout();
      test_ignored();
      test_reset_mid_entry();
      if (exp_q.size() != obs_q.size()) begin
         n_cmp++; n_err++;
         $display("FAIL queue_balance: got %0d observed want %0d expected", obs_q.size(), exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
